alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder.
//  It performs the operation on two operands and returns the result through a valid/ready handshake.
//  A 2-entry result buffer decouples execute from the downstream (MEM/writeback) stage.
//  It also flags the decoder's "unsupported" code 4'b1111.

---
 rtl/alu_exec_unit_pkg.sv | 22 ++
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit_core.sv | 50 +++++
 rtl/alu_exec_unit.sv | 77 +++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes, result-flag struct and overflow helper for the execute stage.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation-in / result-out handshake bundle between issue, the execute ALU and writeback.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_control;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_control, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_control, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_exec_unit_core.sv
// Purely combinational ALU core: (control, a, b) -> (result, zero, ovf, illegal).
module alu_exec_unit_core
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_illegal
);

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic        [WIDTH-1:0] w_sum;
  logic        [WIDTH-1:0] w_bneg;
  logic        [WIDTH-1:0] w_diff;

  assign w_a_s  = i_a;
  assign w_b_s  = i_b;
  assign w_sum  = i_a + i_b;
  assign w_bneg = ~i_b + 1'b1;
  assign w_diff = i_a + w_bneg;

  always_comb begin
    o_result  = '0;
    o_ovf     = 1'b0;
    o_illegal = 1'b0;
    case (i_control)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: begin
        o_result = w_sum;
        o_ovf    = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1]);
      end
      ALU_SUB: begin
        o_result = w_diff;
        o_ovf    = add_ovf(i_a[WIDTH-1], w_bneg[WIDTH-1], w_diff[WIDTH-1]);
      end
      // True signed compare, so the most negative value is below every positive one.
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      default: o_illegal = 1'b1;
    endcase
    o_zero = !o_illegal && (o_result == '0);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a 2-entry result FIFO decoupling execute from MEM/writeback.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  logic [WIDTH-1:0] w_res_p0;
  alu_flags_t       w_flg_p0;
  logic             w_vld_p0;
  logic             w_in_ready;
  logic             w_vld_p1;
  logic             w_pop;

  logic [1:0]       r_count;
  logic             r_wptr;
  logic             r_rptr;
  logic [WIDTH-1:0] r_res_p1 [2];
  alu_flags_t       r_flg_p1 [2];
  logic [TAG_W-1:0] r_tag_p1 [2];

  alu_exec_unit_core #(.WIDTH(WIDTH)) u_core (
    .i_control (bus.in_control),
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .o_result  (w_res_p0),
    .o_zero    (w_flg_p0.zero),
    .o_ovf     (w_flg_p0.ovf),
    .o_illegal (w_flg_p0.illegal)
  );

  // Readiness comes from the occupancy register, gated off while reset is held.
  assign w_in_ready   = !reset && (r_count < 2'd2);
  assign w_vld_p0     = bus.in_valid && w_in_ready;
  assign w_vld_p1     = (r_count != 2'd0);
  assign w_pop        = w_vld_p1 && bus.out_ready;
  assign bus.in_ready = w_in_ready;

  // Stage p0 -> p1: control state (count/pointers) is reset; buffer contents are not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_vld_p0) r_wptr <= ~r_wptr;
      if (w_pop)    r_rptr <= ~r_rptr;
      case ({w_vld_p0, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_vld_p0) begin
      r_res_p1[r_wptr] <= w_res_p0;
      r_flg_p1[r_wptr] <= w_flg_p0;
      r_tag_p1[r_wptr] <= bus.in_tag;
    end
  end

  // Stage p1 output: head entry, forced to zero when the buffer is empty.
  assign bus.out_valid   = w_vld_p1;
  assign bus.out_result  = w_vld_p1 ? r_res_p1[r_rptr]         : '0;
  assign bus.out_zero    = w_vld_p1 ? r_flg_p1[r_rptr].zero    : 1'b0;
  assign bus.out_ovf     = w_vld_p1 ? r_flg_p1[r_rptr].ovf     : 1'b0;
  assign bus.out_illegal = w_vld_p1 ? r_flg_p1[r_rptr].illegal : 1'b0;
  assign bus.out_tag     = w_vld_p1 ? r_tag_p1[r_rptr]         : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomized bench for alu_exec_unit with a queue-based reference model.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t q[$];

  alu_exec_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU computed from the operation definitions with wide signed arithmetic.
  function automatic exp_t ref_op(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] t);
    exp_t   e;
    longint sa, sb, tr;
    e = '0;
    e.tag = t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        tr = sa + sb;
        e.res = tr[31:0];
        e.ovf = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
      end
      4'b0110: begin
        tr = sa - sb;
        e.res = tr[31:0];
        // Negating the most negative B yields itself, so the sign rule flags any negative A.
        if (b == 32'h8000_0000) e.ovf = a[31];
        else e.ovf = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = !e.ill && (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input bit ordy);
    bus.in_valid   = v;
    bus.in_control = c;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_tag     = t;
    bus.out_ready  = ordy;
  endtask

  // One clock: check outputs against the model, then advance the model with this cycle's handshakes.
  task automatic cycle();
    bit   exp_rdy, push, pop;
    exp_t h, nxt;
    #1;
    exp_rdy = !reset && (q.size() < 2);
    if (q.size() != 0) h = q[0];
    else h = '0;
    chk("in_ready",    bus.in_ready,    exp_rdy);
    chk("out_valid",   bus.out_valid,   q.size() != 0);
    chk("out_result",  bus.out_result,  h.res);
    chk("out_zero",    bus.out_zero,    h.zero);
    chk("out_ovf",     bus.out_ovf,     h.ovf);
    chk("out_illegal", bus.out_illegal, h.ill);
    chk("out_tag",     bus.out_tag,     h.tag);
    push = bus.in_valid && exp_rdy;
    pop  = (q.size() != 0) && bus.out_ready;
    nxt  = ref_op(bus.in_control, bus.in_a, bus.in_b, bus.in_tag);
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(nxt);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_ctl();
    case ($urandom_range(0, 6))
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b0010;
      3:       return 4'b0110;
      4:       return 4'b0111;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 0);
    @(negedge clk);

    // Reset held: nothing accepted even with in_valid high.
    cycle();
    drive(1, 4'b0010, 32'd1, 32'd1, 5'd9, 1);
    cycle();
    reset = 1'b0;
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);
    cycle();

    // ADD 5+7 tag 3, visible one cycle after accept.
    drive(1, 4'b0010, 32'd5, 32'd7, 5'd3, 1);
    cycle();
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);
    #1;
    chk("t1_result", bus.out_result, 32'd12);
    chk("t1_tag",    bus.out_tag,    5'd3);
    @(negedge clk);
    q.delete();

    // Zero, overflow and signed-compare corners, back to back.
    drive(1, 4'b0110, 32'd9, 32'd9, 5'd1, 1);                      cycle();
    drive(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd2, 1);              cycle();
    drive(1, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd4, 1);      cycle();
    drive(1, 4'b0110, 32'h8000_0000, 32'd1, 5'd5, 1);              cycle();
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle();

    // Fill with out_ready low, then extra offers are ignored while full.
    drive(1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd6, 0);      cycle();
    drive(1, 4'b0001, 32'h0000_000F, 32'h0000_00F0, 5'd7, 0);      cycle();
    drive(1, 4'b0010, 32'd100, 32'd200, 5'd8, 0);                  cycle();
    // Full with in_valid and out_ready both high: one pop, no push.
    drive(1, 4'b0010, 32'd100, 32'd200, 5'd8, 1);                  cycle();
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle();
    cycle();

    // Illegal codes.
    drive(1, 4'b1111, 32'd3, 32'd3, 5'd10, 1);                     cycle();
    drive(1, 4'b0100, 32'd0, 32'd0, 5'd11, 1);                     cycle();
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle();

    // Full-rate streaming with the consumer always ready.
    for (int i = 0; i < 40; i++) begin
      drive(1, rnd_ctl(), rnd_opnd(), rnd_opnd(), 5'($urandom), 1);
      cycle();
    end

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      drive(bit'($urandom_range(0, 1)), rnd_ctl(), rnd_opnd(), rnd_opnd(),
            5'($urandom), bit'($urandom_range(0, 3) != 0));
      cycle();
    end

    // Fill, then a one-cycle reset discards both entries.
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle(); cycle(); cycle();
    drive(1, 4'b0001, 32'd1, 32'd2, 5'd12, 0);                     cycle();
    drive(1, 4'b0001, 32'd4, 32'd8, 5'd13, 0);                     cycle();
    reset = 1'b1;
    drive(1, 4'b0010, 32'd1, 32'd1, 5'd14, 1);                     cycle();
    reset = 1'b0;
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle();
    cycle();
    drive(1, 4'b0010, 32'd20, 32'd22, 5'd15, 1);                   cycle();
    drive(0, 4'b0000, 32'd0, 32'd0, 5'd0, 1);                      cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
